// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared timing constants and types for the 640x480@60 Hz raster generator.
//   DEF_*            default porch/sync/visible sizes and the values derived from them
//   CNT_W / MAX_TOT  scan counter width and the largest total it can represent
//   color_t          4-bit DAC colour channel
//   blank_gate()     forces a colour channel to 0 outside the visible area
package vga_timing_pkg;

    localparam int DEF_H_VIS = 640;
    localparam int DEF_H_FP  = 16;
    localparam int DEF_H_SW  = 96;
    localparam int DEF_H_BP  = 48;
    localparam int DEF_V_VIS = 480;
    localparam int DEF_V_FP  = 10;
    localparam int DEF_V_SW  = 2;
    localparam int DEF_V_BP  = 33;

    localparam int DEF_H_TOT = DEF_H_VIS + DEF_H_FP + DEF_H_SW + DEF_H_BP;
    localparam int DEF_V_TOT = DEF_V_VIS + DEF_V_FP + DEF_V_SW + DEF_V_BP;

    localparam int DEF_H_SYNC_START = DEF_H_VIS + DEF_H_FP;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SW;
    localparam int DEF_V_SYNC_START = DEF_V_VIS + DEF_V_FP;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SW;

    localparam int CNT_W   = 10;
    localparam int MAX_TOT = 1 << CNT_W;

    typedef logic [3:0] color_t;

    function automatic color_t blank_gate(input logic visible, input color_t c);
        return visible ? c : '0;
    endfunction

endpackage

// File: rtl/scan_counter.sv
// scan_counter
// Mod-N up-counter with enable and terminal-count carry.
//   m_clock  system clock
//   p_reset  synchronous active-low reset, clears count
//   en       count enable
//   count    current value, 0..N-1
//   carry    en && count == N-1, i.e. the cycle in which count wraps to 0
module scan_counter
    import vga_timing_pkg::*;
#(
    parameter int N = DEF_H_TOT,
    parameter int W = CNT_W
)(
    input  logic         m_clock,
    input  logic         p_reset,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         carry
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    assign carry = en && (count == LAST);

    always_ff @(posedge m_clock) begin
        if (!p_reset) begin
            count <= '0;
        end else if (en) begin
            count <= carry ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl
// Raster timing generator and blank-gated pixel output stage for 640x480@60 Hz.
//   m_clock          50 MHz system clock
//   p_reset          synchronous active-low reset
//   htiming          pixel enable (one cycle in two at 25 MHz pixel rate)
//   iR/iG/iB         colour for the current h_count/v_count
//   h_count/v_count  scan position
//   h_en/v_en        position is inside the visible columns / lines
//   hblank_begin     one-cycle pulse as h_count steps H_VIS-1 -> H_VIS
//   vblank_begin     one-cycle pulse as v_count steps V_VIS-1 -> V_VIS
//   h_sync/v_sync    registered active-low syncs
//   oR/oG/oB         registered colour, zero outside the visible area
module vga_scan_ctrl
    import vga_timing_pkg::*;
#(
    parameter int H_VIS = DEF_H_VIS,
    parameter int H_FP  = DEF_H_FP,
    parameter int H_SW  = DEF_H_SW,
    parameter int H_BP  = DEF_H_BP,
    parameter int V_VIS = DEF_V_VIS,
    parameter int V_FP  = DEF_V_FP,
    parameter int V_SW  = DEF_V_SW,
    parameter int V_BP  = DEF_V_BP
)(
    input  logic       m_clock,
    input  logic       p_reset,
    input  logic       htiming,
    input  logic [3:0] iR,
    input  logic [3:0] iG,
    input  logic [3:0] iB,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       h_en,
    output logic       v_en,
    output logic       hblank_begin,
    output logic       vblank_begin,
    output logic       h_sync,
    output logic       v_sync,
    output logic [3:0] oR,
    output logic [3:0] oG,
    output logic [3:0] oB
);

    localparam int H_TOT    = H_VIS + H_FP + H_SW + H_BP;
    localparam int V_TOT    = V_VIS + V_FP + V_SW + V_BP;
    localparam int HS_START = H_VIS + H_FP;
    localparam int HS_END   = HS_START + H_SW;
    localparam int VS_START = V_VIS + V_FP;
    localparam int VS_END   = VS_START + V_SW;

    localparam logic [CNT_W-1:0] H_VIS_C      = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_C      = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] H_LAST_VIS_C = CNT_W'(H_VIS - 1);
    localparam logic [CNT_W-1:0] V_LAST_VIS_C = CNT_W'(V_VIS - 1);
    localparam logic [CNT_W-1:0] HS_START_C   = CNT_W'(HS_START);
    localparam logic [CNT_W-1:0] HS_END_C     = CNT_W'(HS_END);
    localparam logic [CNT_W-1:0] VS_START_C   = CNT_W'(VS_START);
    localparam logic [CNT_W-1:0] VS_END_C     = CNT_W'(VS_END);

    // Totals above 1024 would silently alias in the 10-bit scan counters.
    if (H_TOT > MAX_TOT || V_TOT > MAX_TOT ||
        DEF_H_TOT > MAX_TOT || DEF_V_TOT > MAX_TOT ||
        DEF_H_SYNC_END > DEF_H_TOT || DEF_V_SYNC_END > DEF_V_TOT) begin : g_tot_check
        $error("vga_scan_ctrl: timing totals exceed the 10-bit scan counter range");
    end

    logic h_carry;
    logic v_carry_unused;
    logic visible;

    scan_counter #(.N(H_TOT), .W(CNT_W)) u_h_cnt (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .en      (htiming),
        .count   (h_count),
        .carry   (h_carry)
    );

    scan_counter #(.N(V_TOT), .W(CNT_W)) u_v_cnt (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .en      (h_carry),
        .count   (v_count),
        .carry   (v_carry_unused)
    );

    assign h_en    = (h_count < H_VIS_C);
    assign v_en    = (v_count < V_VIS_C);
    assign visible = h_en && v_en;

    // Outputs are sampled from the pre-increment position, so they trail the
    // counters by exactly one pixel period.  The blank pulses are recomputed
    // every m_clock so they drop after one cycle even while htiming is low.
    always_ff @(posedge m_clock) begin
        if (!p_reset) begin
            oR           <= '0;
            oG           <= '0;
            oB           <= '0;
            h_sync       <= 1'b1;
            v_sync       <= 1'b1;
            hblank_begin <= 1'b0;
            vblank_begin <= 1'b0;
        end else begin
            hblank_begin <= htiming && (h_count == H_LAST_VIS_C);
            vblank_begin <= h_carry && (v_count == V_LAST_VIS_C);
            if (htiming) begin
                oR     <= blank_gate(visible, iR);
                oG     <= blank_gate(visible, iG);
                oB     <= blank_gate(visible, iB);
                h_sync <= !((h_count >= HS_START_C) && (h_count < HS_END_C));
                v_sync <= !((v_count >= VS_START_C) && (v_count < VS_END_C));
            end
        end
    end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
module tb_vga_scan_ctrl;

    logic       m_clock = 1'b0;
    logic       p_reset, htiming, s_reset, s_htiming;
    logic [3:0] iR, iG, iB;

    logic [9:0] d_h_count, d_v_count, s_h_count, s_v_count;
    logic       d_h_en, d_v_en, d_hblank, d_vblank, d_h_sync, d_v_sync;
    logic       s_h_en, s_v_en, s_hblank, s_vblank, s_h_sync, s_v_sync;
    logic [3:0] d_oR, d_oG, d_oB, s_oR, s_oG, s_oB;

    int checks = 0;
    int failures = 0;
    int eh, ev;

    always #10 m_clock = ~m_clock;

    vga_scan_ctrl u_dut (
        .m_clock(m_clock), .p_reset(p_reset), .htiming(htiming),
        .iR(iR), .iG(iG), .iB(iB),
        .h_count(d_h_count), .v_count(d_v_count), .h_en(d_h_en), .v_en(d_v_en),
        .hblank_begin(d_hblank), .vblank_begin(d_vblank),
        .h_sync(d_h_sync), .v_sync(d_v_sync), .oR(d_oR), .oG(d_oG), .oB(d_oB)
    );

    // Small raster: H 8/2/3/2 (15 total), V 6/2/2/3 (13 total), 195 pixels per frame.
    vga_scan_ctrl #(.H_VIS(8), .H_FP(2), .H_SW(3), .H_BP(2),
                    .V_VIS(6), .V_FP(2), .V_SW(2), .V_BP(3)) u_small (
        .m_clock(m_clock), .p_reset(s_reset), .htiming(s_htiming),
        .iR(iR), .iG(iG), .iB(iB),
        .h_count(s_h_count), .v_count(s_v_count), .h_en(s_h_en), .v_en(s_v_en),
        .hblank_begin(s_hblank), .vblank_begin(s_vblank),
        .h_sync(s_h_sync), .v_sync(s_v_sync), .oR(s_oR), .oG(s_oG), .oB(s_oB)
    );

    task automatic step(input logic ht, input logic sht);
        htiming   = ht;
        s_htiming = sht;
        @(negedge m_clock);
    endtask

    task automatic pix();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        if (eh == 799) begin
            eh = 0;
            ev = (ev == 524) ? 0 : ev + 1;
        end else begin
            eh++;
        end
    endtask

    task automatic test_reset();
        p_reset = 1'b0;
        s_reset = 1'b0;
        for (int i = 0; i < 3; i++) step(i % 2 == 0, i % 2 == 0);
        checks++; if (d_h_count !== 10'd0) begin failures++; $display("FAIL reset_h_count got %0d exp 0", d_h_count); end
        checks++; if (d_v_count !== 10'd0) begin failures++; $display("FAIL reset_v_count got %0d exp 0", d_v_count); end
        checks++; if (d_h_sync !== 1'b1 || d_v_sync !== 1'b1) begin failures++; $display("FAIL reset_sync got h=%b v=%b exp 1 1", d_h_sync, d_v_sync); end
        checks++; if ({d_oR, d_oG, d_oB} !== 12'h000) begin failures++; $display("FAIL reset_rgb got %h exp 000", {d_oR, d_oG, d_oB}); end
        checks++; if (d_hblank !== 1'b0 || d_vblank !== 1'b0) begin failures++; $display("FAIL reset_pulses got %b%b exp 00", d_hblank, d_vblank); end
        checks++; if (d_h_en !== 1'b1 || d_v_en !== 1'b1) begin failures++; $display("FAIL reset_en got %b%b exp 11", d_h_en, d_v_en); end
        checks++; if (s_h_count !== 10'd0 || s_v_count !== 10'd0 || s_h_sync !== 1'b1 || s_v_sync !== 1'b1) begin
            failures++; $display("FAIL reset_small got h=%0d v=%0d hs=%b vs=%b exp 0 0 1 1", s_h_count, s_v_count, s_h_sync, s_v_sync);
        end
        p_reset = 1'b1;
        s_reset = 1'b1;
        eh = 0;
        ev = 0;
    endtask

    task automatic test_hsync_line();
        int bad_cnt = 0, bad_hs = 0, bad_col = 0, bad_hb = 0, low_cnt = 0, first_low = -1, hp;
        logic exp_hs;
        iR = 4'hF; iG = 4'hA; iB = 4'h5;
        for (int p = 0; p < 800; p++) begin
            hp = eh;
            step(1'b1, 1'b0);
            if (eh == 799) begin eh = 0; ev++; end else eh++;
            exp_hs = !(hp >= 656 && hp < 752);
            if (d_h_count !== 10'(eh)) bad_cnt++;
            if (d_h_sync !== exp_hs) bad_hs++;
            if (d_h_sync === 1'b0) begin
                low_cnt++;
                if (first_low < 0) first_low = hp;
            end
            if (hp < 640) begin
                if ({d_oR, d_oG, d_oB} !== 12'hFA5) bad_col++;
            end else begin
                if ({d_oR, d_oG, d_oB} !== 12'h000) bad_col++;
            end
            if (d_hblank !== (hp == 639)) bad_hb++;
            if (d_vblank !== 1'b0) bad_hb++;
            step(1'b0, 1'b0);
            if (d_hblank !== 1'b0) bad_hb++;
            if (d_h_count !== 10'(eh)) bad_cnt++;
        end
        checks++; if (bad_cnt != 0) begin failures++; $display("FAIL line_h_count got %0d bad samples exp 0", bad_cnt); end
        checks++; if (bad_hs != 0) begin failures++; $display("FAIL line_h_sync got %0d bad samples exp 0", bad_hs); end
        checks++; if (low_cnt != 96) begin failures++; $display("FAIL hsync_width got %0d exp 96", low_cnt); end
        checks++; if (first_low != 656) begin failures++; $display("FAIL hsync_start got %0d exp 656", first_low); end
        checks++; if (bad_col != 0) begin failures++; $display("FAIL line_rgb_gating got %0d bad samples exp 0", bad_col); end
        checks++; if (bad_hb != 0) begin failures++; $display("FAIL line_blank_pulses got %0d bad samples exp 0", bad_hb); end
        checks++; if (d_v_count !== 10'd1 || d_h_count !== 10'd0) begin failures++; $display("FAIL line_wrap got h=%0d v=%0d exp 0 1", d_h_count, d_v_count); end
        checks++; if (d_v_sync !== 1'b1) begin failures++; $display("FAIL line_v_sync got %b exp 1", d_v_sync); end
    endtask

    task automatic test_stall();
        int bad = 0;
        iR = 4'h0; iG = 4'hA; iB = 4'h0;
        for (int p = 0; p < 800 && eh != 639; p++) pix();
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 1'b0);
            if (d_h_count !== 10'd639 || d_v_count !== 10'd1 || d_oG !== 4'hA || d_h_sync !== 1'b1 || d_hblank !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL stall_frozen got %0d bad cycles exp 0", bad); end
        step(1'b1, 1'b0);
        checks++; if (d_h_count !== 10'd640) begin failures++; $display("FAIL stall_resume_h got %0d exp 640", d_h_count); end
        checks++; if (d_hblank !== 1'b1) begin failures++; $display("FAIL stall_hblank_set got %b exp 1", d_hblank); end
        checks++; if (d_oG !== 4'hA) begin failures++; $display("FAIL stall_last_visible got %h exp a", d_oG); end
        step(1'b0, 1'b0);
        checks++; if (d_hblank !== 1'b0 || d_h_count !== 10'd640) begin failures++; $display("FAIL stall_hblank_clear got hb=%b h=%0d exp 0 640", d_hblank, d_h_count); end
        eh = 640;
        pix();
        checks++; if (d_oG !== 4'h0) begin failures++; $display("FAIL stall_first_blank got %h exp 0", d_oG); end
    endtask

    task automatic test_mid_reset();
        iR = 4'hF; iG = 4'h3; iB = 4'h7;
        for (int p = 0; p < 800 && eh != 700; p++) pix();
        checks++; if (d_h_sync !== 1'b0 || d_h_count !== 10'd700) begin failures++; $display("FAIL midrst_pre got hs=%b h=%0d exp 0 700", d_h_sync, d_h_count); end
        p_reset = 1'b0;
        step(1'b1, 1'b0);
        checks++; if (d_h_count !== 10'd0 || d_v_count !== 10'd0) begin failures++; $display("FAIL midrst_count got h=%0d v=%0d exp 0 0", d_h_count, d_v_count); end
        checks++; if (d_h_sync !== 1'b1 || {d_oR, d_oG, d_oB} !== 12'h000 || d_hblank !== 1'b0) begin
            failures++; $display("FAIL midrst_outputs got hs=%b rgb=%h hb=%b exp 1 000 0", d_h_sync, {d_oR, d_oG, d_oB}, d_hblank);
        end
        p_reset = 1'b1;
        step(1'b0, 1'b0);
        checks++; if (d_h_count !== 10'd0) begin failures++; $display("FAIL midrst_hold got %0d exp 0", d_h_count); end
        step(1'b1, 1'b0);
        checks++; if (d_h_count !== 10'd1 || {d_oR, d_oG, d_oB} !== 12'hF37) begin
            failures++; $display("FAIL midrst_restart got h=%0d rgb=%h exp 1 f37", d_h_count, {d_oR, d_oG, d_oB});
        end
        step(1'b0, 1'b0);
    endtask

    // One full small frame; alt=1 toggles htiming, alt=0 holds it high.
    task automatic run_small_frame(input logic alt, input string tag);
        int sh = 0, sv = 0, hp, vp, hb_cnt = 0, vb_cnt = 0, vb_at = -1, both = 0;
        int vs_low = 0, bad_cnt = 0, bad_sync = 0, bad_col = 0, wide = 0;
        logic saw_wrap = 1'b0, prev_hb = 1'b0;
        iR = 4'h0; iG = 4'hA; iB = 4'h0;
        for (int p = 0; p < 195; p++) begin
            hp = sh; vp = sv;
            step(1'b0, 1'b1);
            if (sh == 14) begin
                sh = 0;
                sv = (sv == 12) ? 0 : sv + 1;
            end else begin
                sh++;
            end
            if (vp == 12 && sv == 0) saw_wrap = 1'b1;
            if (s_h_count !== 10'(sh) || s_v_count !== 10'(sv)) bad_cnt++;
            if (s_h_sync !== !(hp >= 10 && hp < 13) || s_v_sync !== !(vp >= 8 && vp < 10)) bad_sync++;
            if (s_v_sync === 1'b0) vs_low++;
            if (s_oG !== ((hp < 8 && vp < 6) ? 4'hA : 4'h0)) bad_col++;
            if (s_hblank === 1'b1) hb_cnt++;
            if (s_vblank === 1'b1) begin vb_cnt++; vb_at = vp * 15 + hp; end
            if (s_hblank === 1'b1 && s_vblank === 1'b1) both++;
            if (prev_hb && s_hblank === 1'b1) wide++;
            prev_hb = (s_hblank === 1'b1);
            if (alt) begin
                step(1'b0, 1'b0);
                if (s_hblank === 1'b1) hb_cnt++;
                if (s_vblank === 1'b1) vb_cnt++;
                if (s_h_count !== 10'(sh)) bad_cnt++;
                prev_hb = 1'b0;
            end
        end
        checks++; if (bad_cnt != 0) begin failures++; $display("FAIL %s_count got %0d bad samples exp 0", tag, bad_cnt); end
        checks++; if (bad_sync != 0) begin failures++; $display("FAIL %s_sync got %0d bad samples exp 0", tag, bad_sync); end
        checks++; if (vs_low != 30) begin failures++; $display("FAIL %s_vsync_width got %0d exp 30", tag, vs_low); end
        checks++; if (bad_col != 0) begin failures++; $display("FAIL %s_rgb_gating got %0d bad samples exp 0", tag, bad_col); end
        checks++; if (hb_cnt != 13) begin failures++; $display("FAIL %s_hblank_count got %0d exp 13", tag, hb_cnt); end
        checks++; if (vb_cnt != 1) begin failures++; $display("FAIL %s_vblank_count got %0d exp 1", tag, vb_cnt); end
        checks++; if (vb_at != 89) begin failures++; $display("FAIL %s_vblank_pos got %0d exp 89", tag, vb_at); end
        checks++; if (both != 0 || wide != 0) begin failures++; $display("FAIL %s_pulse_overlap got both=%0d wide=%0d exp 0 0", tag, both, wide); end
        checks++; if (!saw_wrap || s_h_count !== 10'd0 || s_v_count !== 10'd0) begin
            failures++; $display("FAIL %s_frame_wrap got wrap=%b h=%0d v=%0d exp 1 0 0", tag, saw_wrap, s_h_count, s_v_count);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        p_reset = 1'b0; s_reset = 1'b0;
        htiming = 1'b0; s_htiming = 1'b0;
        iR = 4'h0; iG = 4'h0; iB = 4'h0;
        @(negedge m_clock);
        test_reset();
        test_hsync_line();
        test_stall();
        test_mid_reset();
        run_small_frame(1'b1, "frame");
        run_small_frame(1'b0, "back_to_back");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_scan_ctrl.md
# vga_scan_ctrl

Raster timing generator and pixel output stage for 640x480@60 Hz VGA. Sits directly downstream of the GPU/background colour mux. It produces the scan position (`h_count`/`v_count`), the blanking-edge pulses that drive the GPU's line and frame sequencing, and the registered, blank-gated RGB and sync outputs for the board DAC. Pixel rate is 25 MHz, derived from `m_clock` by a one-cycle-in-two `htiming` enable.

## Interface
- `H_VIS`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SW`, 96, hsync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_VIS`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SW`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `m_clock`  in  1  system clock (50 MHz)
- `p_reset`  in  1  reset: synchronous, active-low, sampled on the rising edge of `m_clock`
- `htiming`  in  1  pixel enable; all state advances only in cycles where it is 1
- `iR`/`iG`/`iB`  in  4 each  pixel colour for the current `h_count`/`v_count`
- `h_count`  out  10  current pixel column, 0..799
- `v_count`  out  10  current line, 0..524
- `h_en`  out  1  `h_count < H_VIS` (combinational from the register)
- `v_en`  out  1  `v_count < V_VIS` (combinational from the register)
- `hblank_begin`  out  1  one-`m_clock` pulse at the start of each horizontal blank
- `vblank_begin`  out  1  one-`m_clock` pulse at the start of vertical blank
- `h_sync`/`v_sync`  out  1  active-low syncs, registered
- `oR`/`oG`/`oB`  out  4 each  registered colour, forced to 0 outside the visible area

## Operation
- Totals: `H_TOT = H_VIS+H_FP+H_SW+H_BP` (800) and `V_TOT` (525). Both must be ≤ 1024, which is checked at elaboration.
- Horizontal counter, on each `htiming` edge:
  - `h_count` increments.
  - At `H_TOT-1` it wraps to 0 and asserts a line carry.
- Vertical counter: increments only on the line carry, and wraps `V_TOT-1` to 0.
- Output registers, on each `htiming` edge, sampled from the pre-increment `(h,v)`:
  - `oX <= (h<H_VIS && v<V_VIS) ? iX : 0`
  - `h_sync <= !(h >= H_VIS+H_FP && h < H_VIS+H_FP+H_SW)`, i.e. low for h = 656..751
  - `v_sync <= !(v >= V_VIS+V_FP && v < V_VIS+V_FP+V_SW)`, i.e. low for v = 490..491
- `hblank_begin`:
  - Set to 1 on the `htiming` edge where `h_count` goes `H_VIS-1` → `H_VIS`, on every line including blank lines.
  - Cleared on the next `m_clock` edge, so the pulse width is exactly 1 `m_clock`.
- `vblank_begin`:
  - Set on the `htiming` edge where `v_count` goes `V_VIS-1` → `V_VIS` (h wraps 799→0 with v = 479).
  - Also exactly 1 `m_clock` wide.
- `htiming` held low: every register holds its value. The pulse outputs still clear after their single cycle.
- Reset (`p_reset`=0 at a clock edge), whether at power-up or mid-frame:
  - `h_count`=0, `v_count`=0, `h_sync`=1, `v_sync`=1, `oR`/`oG`/`oB`=0, `hblank_begin`=0, `vblank_begin`=0.
  - Therefore `h_en`=1 and `v_en`=1.
  - Reset overrides `htiming`. Counting resumes on the first `htiming` after release.

## Timing
- Colour and sync outputs lag the counters by one pixel period (2 `m_clock`).
- The GPU therefore presents `iX` for the `(h_count, v_count)` currently displayed. No additional pipeline stage is allowed.
- Line period: 800 `htiming` pulses (1600 `m_clock` at a 50 % enable). Frame period: 420 000 `htiming` pulses.
- `hblank_begin` fires 525 times per frame. `vblank_begin` fires once per frame.
- When `vblank_begin` fires, `hblank_begin` fires on a different edge (h = 640 of line 479, one line segment earlier), never in the same cycle.

## Structure
- Package `vga_timing_pkg` holds:
  - the eight default timing constants
  - the derived `H_TOT`, `V_TOT`, and the sync start/end constants
  - the shared 4-bit colour type
- Sub-module `scan_counter`: a parameterised mod-N counter with enable and a terminal-count carry. It is instanced twice: horizontal (enable = `htiming`) and vertical (enable = `htiming` & h-carry).

## Test plan
- Reset: hold `p_reset`=0 for 3 cycles while `htiming` toggles → all outputs at reset values, `h_count`=0, `v_count`=0.
- Hsync: `htiming` alternating, `iR`=4'hF → `h_sync` low for exactly 96 pixel periods, starting one pixel after `h_count`=656; `oR`=F only for pixels 0..639.
- Frame wrap: run 420 000 pixels → `v_count` returns 0 from 524; exactly one `vblank_begin` (after v 479→480) and 525 `hblank_begin` pulses; `v_sync` low for 1600 pixel periods.
- Blank gating: `iG`=4'hA constant → `oG`=0 for lines 480..524 and columns 640..799, `oG`=A elsewhere.
- Enable stall: hold `htiming`=0 for 50 cycles at h=639 → counters and outputs frozen; next `htiming` gives h=640 and a single 1-cycle `hblank_begin`.
- Mid-frame reset: assert `p_reset`=0 at h=700, v=300 → next edge gives h=0, v=0, `h_sync`=1, colour 0; normal sequence restarts.
